// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Program loader for the 16-bit custom RISC core. Symbolic instruction fields
// arrive over a valid/ready handshake, are packed into 16-bit instruction
// words and written sequentially into instruction memory starting at a
// caller-supplied address. A load ends on an accepted HALT or when the last
// memory address has been written.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   start       single-cycle pulse, begins a load at start_addr (IDLE/DONE only)
//   start_addr  first word address of the load
//   in_valid    instruction fields valid
//   in_ready    fields are accepted this cycle (high while loading)
//   in_op       4-bit opcode
//   in_rs/rt/rd 3-bit register fields
//   in_imm      12-bit immediate or jump target
//   mem_we      instruction-memory write strobe (one cycle per word)
//   mem_addr    write address
//   mem_wdata   encoded instruction word
//   err         one-cycle pulse for an accepted but rejected word
//   err_count   saturating reject count since the last start
//   done        load finished (level, until start or reset)
//   overflow    load ended by writing the last memory address (level)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [11:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              done,
  output logic              overflow
);

  // Opcode map of the core's instruction set.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_J    = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1011;
  localparam logic [3:0] OP_JR   = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1101;
  localparam logic [3:0] OP_ORI  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   ptr_q,       ptr_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                err_q,       err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic                done_q,      done_d;
  logic                overflow_q,  overflow_d;
  logic                end_ovf_q,   end_ovf_d;

  logic [15:0]         enc_word;
  logic                enc_legal;
  logic                imm_fits_signed;
  logic                imm_fits_unsigned;
  logic                accept;
  logic                is_halt;
  logic                ptr_at_end;

  // A 6-bit signed immediate is representable only when the discarded upper
  // bits are pure sign extension of bit 5.
  assign imm_fits_signed   = (&in_imm[11:5]) | ~(|in_imm[11:5]);
  assign imm_fits_unsigned = ~(|in_imm[11:6]);

  assign accept     = in_valid && (state_q == ST_LOAD);
  assign is_halt    = (in_op == OP_HALT);
  assign ptr_at_end = &ptr_q;

  // Pack the symbolic fields into an instruction word and decide whether the
  // immediate fits the target format. Unused bit positions stay zero.
  always_comb begin
    enc_word  = 16'h0000;
    enc_legal = 1'b1;
    case (in_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        enc_word = {in_op, in_rs, in_rt, in_rd, 3'b000};
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
        enc_word  = {in_op, in_rs, in_rt, in_imm[5:0]};
        enc_legal = imm_fits_signed;
      end
      OP_LUI, OP_ORI: begin
        enc_word  = {in_op, in_rs, in_rt, in_imm[5:0]};
        enc_legal = imm_fits_unsigned;
      end
      OP_J, OP_JAL: begin
        enc_word = {in_op, in_imm};
      end
      OP_JR: begin
        enc_word = {in_op, in_rs, 9'b0_0000_0000};
      end
      default: begin
        enc_word = 16'hF000;
      end
    endcase
  end

  // Next-state logic for the load sequencer and its registered outputs.
  // The pointer is never advanced past the last address: the word written
  // there always terminates the load, so wrapping cannot happen.
  // done/overflow rise one cycle after the DONE state is entered so that the
  // final write is already visible on the memory port when done goes high.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    end_ovf_d   = end_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          ptr_d       = start_addr;
          err_count_d = 8'h00;
          done_d      = 1'b0;
          overflow_d  = 1'b0;
          end_ovf_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (enc_legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = enc_word;
            if (is_halt) begin
              state_d   = ST_DONE;
              end_ovf_d = 1'b0;
            end else if (ptr_at_end) begin
              state_d   = ST_DONE;
              end_ovf_d = 1'b1;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          ptr_d       = start_addr;
          err_count_d = 8'h00;
          done_d      = 1'b0;
          overflow_d  = 1'b0;
          end_ovf_d   = 1'b0;
        end else if (!done_q) begin
          done_d     = 1'b1;
          overflow_d = end_ovf_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, which also
  // drops any write that was queued for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      end_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      end_ovf_q   <= end_ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Bench for instr_encoder_loader. Two instances share the input stimulus:
// a full-size one (ADDR_W = 8) and a tiny one (ADDR_W = 2) used to reach the
// end of memory quickly. Expected words come from a arithmetic reference
// encoder and a small load model kept in this file.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'h0;
  logic [2:0]  in_rs = 3'd0;
  logic [2:0]  in_rt = 3'd0;
  logic [2:0]  in_rd = 3'd0;
  logic [11:0] in_imm = 12'h000;

  logic        in_ready, mem_we, err, done, overflow;
  logic [7:0]  mem_addr, err_count;
  logic [15:0] mem_wdata;

  logic        s_in_ready, s_mem_we, s_err, s_done, s_overflow;
  logic [1:0]  s_mem_addr;
  logic [7:0]  s_err_count;
  logic [15:0] s_mem_wdata;

  int checks = 0;
  int passed = 0;

  // Load model state.
  bit          m_loading, m_finished, m_ovf;
  int          m_ptr, m_fin_edges, m_errcnt;
  bit          e_we, e_err;
  logic [7:0]  e_addr;
  logic [15:0] e_data;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err(err), .err_count(err_count), .done(done), .overflow(overflow)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr[1:0]),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .err(s_err), .err_count(s_err_count), .done(s_done), .overflow(s_overflow)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference encoder: builds the word with plain field weights and checks
  // the immediate against its numeric range.
  function automatic void ref_encode(input logic [3:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [2:0] rd,
                                     input logic [11:0] imm,
                                     output logic [15:0] w, output bit ok);
    int o, u_val, s_val, v;
    o     = int'(op);
    u_val = int'(imm);
    s_val = (u_val >= 2048) ? u_val - 4096 : u_val;
    ok    = 1'b1;
    v     = 0;
    case (o)
      0, 1, 2, 3, 7: v = o * 4096 + int'(rs) * 512 + int'(rt) * 64 + int'(rd) * 8;
      4, 5, 6, 8, 9: begin
        v  = o * 4096 + int'(rs) * 512 + int'(rt) * 64 + (u_val % 64);
        ok = (s_val >= -32) && (s_val <= 31);
      end
      13, 14: begin
        v  = o * 4096 + int'(rs) * 512 + int'(rt) * 64 + (u_val % 64);
        ok = (u_val <= 63);
      end
      10, 11: v = o * 4096 + u_val;
      12:     v = o * 4096 + int'(rs) * 512;
      default: v = 61440;
    endcase
    w = 16'(v);
  endfunction

  // Advance the load model by one clock edge using the currently driven
  // inputs; leaves the expected write/err outcome for the following cycle.
  task automatic model_step();
    logic [15:0] w;
    bit ok;
    e_we  = 1'b0;
    e_err = 1'b0;
    if (m_finished) m_fin_edges++;
    if (m_loading && in_valid) begin
      ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, w, ok);
      if (ok) begin
        e_we   = 1'b1;
        e_addr = 8'(m_ptr);
        e_data = w;
        if (in_op == 4'hF || m_ptr == 255) begin
          m_loading   = 1'b0;
          m_finished  = 1'b1;
          m_fin_edges = 1;
          m_ovf       = (in_op != 4'hF);
        end else begin
          m_ptr++;
        end
      end else begin
        e_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end else if (start && !m_loading) begin
      m_loading   = 1'b1;
      m_ptr       = int'(start_addr);
      m_errcnt    = 0;
      m_finished  = 1'b0;
      m_ovf       = 1'b0;
      m_fin_edges = 0;
    end
  endtask

  task automatic set_fields(input logic v, input logic [3:0] op, input logic [2:0] rs,
                            input logic [2:0] rt, input logic [2:0] rd,
                            input logic [11:0] imm);
    in_valid = v;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
  endtask

  // Random fields drawn from an opcode that is legal for any immediate.
  task automatic pick_legal();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: in_op = 4'h0;  1: in_op = 4'h1;  2: in_op = 4'h2;  3: in_op = 4'h3;
      4: in_op = 4'h7;  5: in_op = 4'hA;  6: in_op = 4'hB;  default: in_op = 4'hC;
    endcase
    in_valid = 1'b1;
    in_rs  = 3'($urandom_range(0, 7));
    in_rt  = 3'($urandom_range(0, 7));
    in_rd  = 3'($urandom_range(0, 7));
    in_imm = 12'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = 8'h00;
    set_fields(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 12'h000);
    m_loading = 1'b0; m_finished = 1'b0; m_ovf = 1'b0;
    m_ptr = 0; m_fin_edges = 0; m_errcnt = 0;
    e_we = 1'b0; e_err = 1'b0; e_addr = 8'h00; e_data = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset values on both instances, and no activity while IDLE.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, mem_we, err, done, overflow} !== 5'b0) $display("[TB] FAIL reset_flags got %b want 00000", {in_ready, mem_we, err, done, overflow}); else passed++;
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) $display("[TB] FAIL reset_bus got %h/%h want 00/0000", mem_addr, mem_wdata); else passed++;
    checks++; if (err_count !== 8'h00) $display("[TB] FAIL reset_errcnt got %0d want 0", err_count); else passed++;
    checks++; if ({s_in_ready, s_mem_we, s_err, s_done, s_overflow} !== 5'b0) $display("[TB] FAIL reset_small got %b want 00000", {s_in_ready, s_mem_we, s_err, s_done, s_overflow}); else passed++;
    rst_n = 1'b1;
    set_fields(1'b1, 4'h0, 3'd1, 3'd2, 3'd3, 12'h000);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) $display("[TB] FAIL idle_no_accept got we=%b ready=%b want 0/0", mem_we, in_ready); else passed++;
    in_valid = 1'b0;
  endtask

  // Directed encodings, rejection, HALT termination and an ignored start
  // that coincides with the terminating accept.
  task automatic test_encoding();
    do_reset();
    start = 1'b1; start_addr = 8'h10;
    @(negedge clk);
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL enc_ready got %b want 1", in_ready); else passed++;
    set_fields(1'b1, 4'h0, 3'd1, 3'd2, 3'd3, 12'h000);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'h0298) $display("[TB] FAIL enc_add got we=%b %h:%h want 1 10:0298", mem_we, mem_addr, mem_wdata); else passed++;
    set_fields(1'b1, 4'h4, 3'd1, 3'd2, 3'd0, 12'hFFF);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 16'h42BF) $display("[TB] FAIL enc_addi got we=%b %h:%h want 1 11:42BF", mem_we, mem_addr, mem_wdata); else passed++;
    set_fields(1'b1, 4'h4, 3'd1, 3'd2, 3'd0, 12'hFDF);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || err !== 1'b1 || err_count !== 8'd1) $display("[TB] FAIL enc_addi_rej got we=%b err=%b cnt=%0d want 0 1 1", mem_we, err, err_count); else passed++;
    set_fields(1'b1, 4'hA, 3'd0, 3'd0, 3'd0, 12'hABC);
    @(negedge clk);
    checks++; if (err !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h12 || mem_wdata !== 16'hAABC) $display("[TB] FAIL enc_j got err=%b we=%b %h:%h want 0 1 12:AABC", err, mem_we, mem_addr, mem_wdata); else passed++;
    set_fields(1'b1, 4'hE, 3'd1, 3'd2, 3'd0, 12'h03F);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h13 || mem_wdata !== 16'hE2BF) $display("[TB] FAIL enc_ori got we=%b %h:%h want 1 13:E2BF", mem_we, mem_addr, mem_wdata); else passed++;
    set_fields(1'b1, 4'hD, 3'd1, 3'd2, 3'd0, 12'h040);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || err !== 1'b1 || err_count !== 8'd2) $display("[TB] FAIL enc_lui_rej got we=%b err=%b cnt=%0d want 0 1 2", mem_we, err, err_count); else passed++;
    set_fields(1'b1, 4'hF, 3'd3, 3'd4, 3'd5, 12'h123);
    start = 1'b1; start_addr = 8'h40;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h14 || mem_wdata !== 16'hF000) $display("[TB] FAIL enc_halt got we=%b %h:%h want 1 14:F000", mem_we, mem_addr, mem_wdata); else passed++;
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) $display("[TB] FAIL halt_n1 got ready=%b done=%b want 0/0", in_ready, done); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b1 || overflow !== 1'b0 || mem_we !== 1'b0) $display("[TB] FAIL halt_n2 got done=%b ovf=%b we=%b want 1 0 0", done, overflow, mem_we); else passed++;
    checks++; if (in_ready !== 1'b0 || err_count !== 8'd2) $display("[TB] FAIL start_in_load got ready=%b cnt=%0d want 0 2", in_ready, err_count); else passed++;
  endtask

  // Tiny memory: a reject, then back-to-back words run off the end; then a
  // start from DONE clears the status and loads at the new address.
  task automatic test_end_of_memory();
    logic [15:0] w0, w1, w3;
    bit ok;
    do_reset();
    start = 1'b1; start_addr = 8'h02;
    @(negedge clk);
    start = 1'b0;
    set_fields(1'b1, 4'hD, 3'd0, 3'd0, 3'd0, 12'h040);
    @(negedge clk);
    checks++; if (s_err !== 1'b1 || s_err_count !== 8'd1 || s_mem_we !== 1'b0) $display("[TB] FAIL eom_rej got err=%b cnt=%0d we=%b want 1 1 0", s_err, s_err_count, s_mem_we); else passed++;
    pick_legal(); ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, w0, ok);
    @(negedge clk);
    checks++; if (s_mem_we !== 1'b1 || s_mem_addr !== 2'd2 || s_mem_wdata !== w0) $display("[TB] FAIL eom_w0 got we=%b %h:%h want 1 2:%h", s_mem_we, s_mem_addr, s_mem_wdata, w0); else passed++;
    pick_legal(); ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, w1, ok);
    @(negedge clk);
    checks++; if (s_mem_we !== 1'b1 || s_mem_addr !== 2'd3 || s_mem_wdata !== w1) $display("[TB] FAIL eom_w1 got we=%b %h:%h want 1 3:%h", s_mem_we, s_mem_addr, s_mem_wdata, w1); else passed++;
    checks++; if (s_in_ready !== 1'b0) $display("[TB] FAIL eom_ready got %b want 0", s_in_ready); else passed++;
    pick_legal();
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (s_mem_we !== 1'b0 || s_done !== 1'b1 || s_overflow !== 1'b1) $display("[TB] FAIL eom_done got we=%b done=%b ovf=%b want 0 1 1", s_mem_we, s_done, s_overflow); else passed++;
    start = 1'b1; start_addr = 8'h01;
    @(negedge clk);
    start = 1'b0;
    checks++; if (s_done !== 1'b0 || s_overflow !== 1'b0 || s_err_count !== 8'd0 || s_in_ready !== 1'b1) $display("[TB] FAIL restart_clear got done=%b ovf=%b cnt=%0d ready=%b want 0 0 0 1", s_done, s_overflow, s_err_count, s_in_ready); else passed++;
    pick_legal(); ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, w3, ok);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (s_mem_we !== 1'b1 || s_mem_addr !== 2'd1 || s_mem_wdata !== w3) $display("[TB] FAIL restart_write got we=%b %h:%h want 1 1:%h", s_mem_we, s_mem_addr, s_mem_wdata, w3); else passed++;
  endtask

  // Reset right after an accept: the queued write never appears and all
  // outputs clear at once; a fresh load then works normally.
  task automatic test_reset_mid_load();
    logic [15:0] w;
    bit ok;
    do_reset();
    start = 1'b1; start_addr = 8'h20;
    @(negedge clk);
    start = 1'b0;
    set_fields(1'b1, 4'hD, 3'd0, 3'd0, 3'd0, 12'h040);
    @(negedge clk);
    set_fields(1'b1, 4'h1, 3'd4, 3'd5, 3'd6, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || err_count !== 8'd0) $display("[TB] FAIL rst_mid got we=%b ready=%b cnt=%0d want 0 0 0", mem_we, in_ready, err_count); else passed++;
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000 || done !== 1'b0) $display("[TB] FAIL rst_mid_bus got %h:%h done=%b want 00:0000 0", mem_addr, mem_wdata, done); else passed++;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL rst_hold_we got %b want 0", mem_we); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; start_addr = 8'h30;
    @(negedge clk);
    start = 1'b0;
    pick_legal(); ref_encode(in_op, in_rs, in_rt, in_rd, in_imm, w, ok);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== w) $display("[TB] FAIL rst_reload got we=%b %h:%h want 1 30:%h", mem_we, mem_addr, mem_wdata, w); else passed++;
  endtask

  // Long run of rejected words: the counter stops at 255.
  task automatic test_err_saturation();
    do_reset();
    start = 1'b1; start_addr = 8'h00;
    @(negedge clk);
    start = 1'b0;
    set_fields(1'b1, 4'hE, 3'd1, 3'd1, 3'd0, 12'h7C0);
    for (int i = 0; i < 260; i++) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255 || err !== 1'b1) $display("[TB] FAIL err_sat got cnt=%0d err=%b want 255 1", err_count, err); else passed++;
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL err_sat_state got we=%b ready=%b want 0 1", mem_we, in_ready); else passed++;
  endtask

  // Randomized back-to-back stream checked every cycle against the model,
  // including restarts, high start addresses and stray starts during a load.
  task automatic test_back_to_back();
    bit exp_done;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_done = m_finished && (m_fin_edges >= 2);
      checks++; if (in_ready !== m_loading) $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, m_loading); else passed++;
      checks++; if (mem_we !== e_we) $display("[TB] FAIL rnd_we cyc %0d got %b want %b", c, mem_we, e_we); else passed++;
      if (e_we) begin
        checks++; if (mem_addr !== e_addr || mem_wdata !== e_data) $display("[TB] FAIL rnd_write cyc %0d got %h:%h want %h:%h", c, mem_addr, mem_wdata, e_addr, e_data); else passed++;
      end
      checks++; if (err !== e_err || err_count !== 8'(m_errcnt)) $display("[TB] FAIL rnd_err cyc %0d got %b/%0d want %b/%0d", c, err, err_count, e_err, m_errcnt); else passed++;
      checks++; if (done !== exp_done || overflow !== (exp_done && m_ovf)) $display("[TB] FAIL rnd_status cyc %0d got done=%b ovf=%b want %b %b", c, done, overflow, exp_done, exp_done && m_ovf); else passed++;
      start = ($urandom_range(0, 9) == 0);
      start_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
      in_valid = ($urandom_range(0, 9) < 7);
      in_op = 4'($urandom_range(0, 15));
      if (in_op == 4'hF && $urandom_range(0, 3) != 0) in_op = 4'($urandom_range(0, 14));
      in_rs = 3'($urandom_range(0, 7));
      in_rt = 3'($urandom_range(0, 7));
      in_rd = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       in_imm = 12'($urandom_range(0, 63) - 32);
        1:       in_imm = 12'($urandom_range(0, 127));
        default: in_imm = 12'($urandom);
      endcase
      model_step();
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout reached, got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_encoding();
    test_end_of_memory();
    test_reset_mid_load();
    test_err_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
